tdm_demux_1to8: RTL
===================

Name: tdm_demux_1to8

Overview:
Time-division demultiplexer: the receive end of a TDM serial link whose transmit end is an 8:1 slot-selecting mux. It takes one serial bit per valid beat, tracks the slot position from a frame sync marker, and deposits slot k into bit k of an 8-bit parallel word. A completed frame is presented as a registered word with a one-cycle frame_valid strobe. It sits between the serial link and parallel consumers.

Parameters:
NSLOT, 8, slots per frame; power of 2, >= 2; sets width of Y and slot.
STRICT_SYNC, 1, 1: sync is required on every slot-0 beat while locked; 0: sync is only used to acquire and re-align.

Ports:
clk  input  1  single clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
din  input  1  serial data bit.
din_valid  input  1  beat qualifier; din and sync are sampled only when high.
sync  input  1  high on the beat that carries slot 0.
Y  output  NSLOT  last complete frame; bit k = slot k.
frame_valid  output  1  one-cycle pulse when Y is updated.
slot  output  log2(NSLOT)  slot index expected on the next valid beat.
locked  output  1  high in the LOCKED state.
sync_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst high at an edge) sets: state HUNT, cnt 0, shadow 0, Y 0, frame_valid 0, sync_err 0, locked 0. Reset has priority over all other inputs and aborts any partial frame.
- All outputs are registered. slot = cnt. locked = (state == LOCKED).
- din_valid low: state, cnt and shadow hold; frame_valid and sync_err are 0.
- HUNT state:
  - Valid beat with sync=0: the beat is dropped.
  - Valid beat with sync=1: shadow[0] <= din, cnt <= 1, next state LOCKED.
- LOCKED state, valid beat:
  - sync=1 with cnt != 0 (early sync): sync_err pulse; the partial frame is discarded (shadow cleared); this beat is taken as slot 0 (shadow[0] <= din, cnt <= 1); state stays LOCKED.
  - sync=0 with cnt == 0 and STRICT_SYNC=1 (missing sync): sync_err pulse; the beat is dropped; next state HUNT.
  - sync=0 with cnt == 0 and STRICT_SYNC=0: the beat is taken as slot 0.
  - Otherwise: shadow[cnt] <= din, and cnt increments.
- Frame completion, on the valid beat with cnt == NSLOT-1:
  - Y <= {din, shadow[NSLOT-2:0]}.
  - frame_valid pulses for one cycle.
  - cnt wraps to 0.
- Latency: Y and frame_valid change at the edge that samples the last slot, so they are visible in the following cycle. Y holds until the next completed frame.
- Partial frames never reach Y.
- Back-to-back frames with continuous valid beats give a frame_valid pulse every NSLOT cycles, with no bubble.
- Stalls (din_valid low) inside a frame are allowed for any length; slot position is preserved.

Decomposition:
- Package tdm_pkg holds:
  - the state enum (HUNT, LOCKED);
  - the NSLOT default localparam;
  - the slot index typedef slot_t (logic [$clog2(NSLOT)-1:0]).
- Sub-module tdm_slot_cnt: a slot counter with synchronous clear, load-to-1 and enable-increment; wraps at NSLOT-1 and outputs a last-slot flag.
- The top level holds the FSM, the shadow register and the output register.

Test Plan:
- Aligned frame: sync on the first beat; din slots 0..7 = 1,0,1,1,0,0,1,0, continuous valid -> Y=8'h4D one cycle after the 8th beat; frame_valid high exactly 1 cycle; locked=1; sync_err=0.
- Stall tolerance: same frame with din_valid low for 3 cycles after slot 3 and for 1 cycle after slot 6 -> Y=8'h4D; slot holds at 4 during the stall; frame_valid pulses once.
- Hunt: 5 valid beats with sync=0 after reset -> locked=0 and no frame_valid; then an aligned frame of all ones -> Y=8'hFF.
- Early sync: sync again at slot 5 -> sync_err pulses once and no frame_valid; the new 8-beat frame 0,1,0,1,0,1,0,1 -> Y=8'hAA.
- Missing sync (STRICT_SYNC=1): after a good frame, the next slot-0 beat has sync=0 -> sync_err pulses and locked=0 next cycle; Y holds the previous value. With STRICT_SYNC=0 the same stimulus produces a second frame and no sync_err.
- Reset mid-frame: rst high at slot 4 -> next cycle Y=0, slot=0, locked=0; a subsequent aligned frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux_1to8_pkg.sv
// Shared types and defaults for the TDM 1:8 demultiplexer.
package tdm_pkg;

    // Default number of slots per frame.
    localparam int NSLOT_DEFAULT = 8;

    // Slot index type for the default frame size.
    typedef logic [$clog2(NSLOT_DEFAULT)-1:0] slot_t;

    // Framing state: HUNT waits for a sync beat, LOCKED tracks slot position.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_demux_1to8_slot_cnt.sv
// Slot position counter: synchronous clear, load-to-1 for a new slot 0,
// enable-increment that wraps after the last slot, and a last-slot flag.
module tdm_slot_cnt #(
    parameter int NSLOT = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     load1,
    input  logic                     inc,
    output logic [$clog2(NSLOT)-1:0] cnt,
    output logic                     last
);

    localparam int SW = $clog2(NSLOT);
    localparam logic [SW-1:0] LAST_IDX = SW'(NSLOT - 1);

    logic [SW-1:0] cnt_r;

    // Counter register: clear beats load, load beats increment.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {SW{1'b0}};
        end else if (load1) begin
            cnt_r <= SW'(1);
        end else if (inc) begin
            if (cnt_r == LAST_IDX) begin
                cnt_r <= {SW{1'b0}};
            end else begin
                cnt_r <= cnt_r + SW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign last = (cnt_r == LAST_IDX);

endmodule

// File: rtl/tdm_demux_1to8.sv
// Receive side of an 8:1 TDM link: aligns on the sync marker, gathers one
// bit per valid beat into a shadow word and publishes whole frames on Y.
module tdm_demux_1to8
    import tdm_pkg::*;
#(
    parameter int NSLOT       = NSLOT_DEFAULT,
    parameter bit STRICT_SYNC = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din,
    input  logic                     din_valid,
    input  logic                     sync,
    output logic [NSLOT-1:0]         Y,
    output logic                     frame_valid,
    output logic [$clog2(NSLOT)-1:0] slot,
    output logic                     locked,
    output logic                     sync_err
);

    localparam int SW = $clog2(NSLOT);

    tdm_state_e     state_r;
    logic [NSLOT-1:0] shadow_r;
    logic [NSLOT-1:0] y_r;
    logic           fv_r;
    logic           err_r;
    logic           locked_r;

    logic [SW-1:0]  cnt_s;
    logic           last_s;
    logic           load1_s;
    logic           inc_s;
    logic           start_s;
    logic           wr_s;
    logic           done_s;
    logic           err_s;
    logic           go_lock_s;
    logic           go_hunt_s;

    tdm_slot_cnt #(.NSLOT(NSLOT)) u_cnt (
        .clk   (clk),
        .clr   (rst),
        .load1 (load1_s),
        .inc   (inc_s),
        .cnt   (cnt_s),
        .last  (last_s)
    );

    // Beat decode: decide whether this beat starts a frame, fills a slot,
    // is dropped, or flags a framing error.
    always_comb begin
        load1_s   = 1'b0;
        inc_s     = 1'b0;
        start_s   = 1'b0;
        wr_s      = 1'b0;
        done_s    = 1'b0;
        err_s     = 1'b0;
        go_lock_s = 1'b0;
        go_hunt_s = 1'b0;
        if (din_valid) begin
            case (state_r)
                HUNT: begin
                    if (sync) begin
                        load1_s   = 1'b1;
                        start_s   = 1'b1;
                        go_lock_s = 1'b1;
                    end else begin
                        load1_s = 1'b0;
                    end
                end
                LOCKED: begin
                    if (sync && (cnt_s != {SW{1'b0}})) begin
                        // Early sync: throw away the partial frame and realign.
                        err_s   = 1'b1;
                        load1_s = 1'b1;
                        start_s = 1'b1;
                    end else if (!sync && (cnt_s == {SW{1'b0}}) && (STRICT_SYNC == 1'b1)) begin
                        // Missing sync on slot 0: drop the beat and hunt again.
                        err_s     = 1'b1;
                        go_hunt_s = 1'b1;
                    end else begin
                        wr_s   = 1'b1;
                        inc_s  = 1'b1;
                        done_s = last_s;
                    end
                end
                default: begin
                    go_hunt_s = 1'b1;
                end
            endcase
        end else begin
            err_s = 1'b0;
        end
    end

    // Framing FSM, shadow word and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= HUNT;
            locked_r <= 1'b0;
            shadow_r <= {NSLOT{1'b0}};
            y_r      <= {NSLOT{1'b0}};
            fv_r     <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            fv_r  <= done_s;
            err_r <= err_s;
            if (go_lock_s) begin
                state_r  <= LOCKED;
                locked_r <= 1'b1;
            end else if (go_hunt_s) begin
                state_r  <= HUNT;
                locked_r <= 1'b0;
            end else begin
                state_r  <= state_r;
                locked_r <= locked_r;
            end
            if (start_s) begin
                shadow_r <= {{(NSLOT-1){1'b0}}, din};
            end else if (wr_s) begin
                shadow_r[cnt_s] <= din;
            end else begin
                shadow_r <= shadow_r;
            end
            if (done_s) begin
                y_r <= {din, shadow_r[NSLOT-2:0]};
            end else begin
                y_r <= y_r;
            end
        end
    end

    assign Y           = y_r;
    assign frame_valid = fv_r;
    assign sync_err    = err_r;
    assign locked      = locked_r;
    assign slot        = cnt_s;

endmodule
